// File: rtl/clkdiv_seq.sv
// Programmable clock divider with glitch-free ratio change at low-going boundaries.
// Optional complementary output CLKON when GF180MCU_CLKDIV_COMPL_OUT_EN is defined.
module clkdiv_seq (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic [3:0] DIV,
  input  logic       REQ,
  output logic       ACK,
  output logic       BUSY,
  output logic       CLKO,
  output logic       TICK,
`ifdef GF180MCU_CLKDIV_COMPL_OUT_EN
  output logic       CLKON,
`endif
  inout  wire        VDD,
  inout  wire        VSS
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] DIV_RST = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] act_div_q, act_div_d;
  logic [CW-1:0] nxt_div_q, nxt_div_d;
  logic          clko_q, clko_d;
  logic          tick_q, tick_d;
  logic          ack_q, ack_d;
  logic          busy_q, busy_d;
`ifdef GF180MCU_CLKDIV_COMPL_OUT_EN
  logic          clkon_q;
`endif

  logic at_top;
  logic fall;
  logic stop;
  logic unused_supply;

  assign unused_supply = VDD ^ VSS;

  assign at_top = (cnt_q == act_div_q);
  assign fall   = at_top & clko_q;
  // Disable takes effect immediately when low, otherwise at the end of the high phase.
  assign stop   = ~EN & (~clko_q | fall);

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      act_div_q <= DIV_RST;
      nxt_div_q <= DIV_RST;
      clko_q    <= 1'b0;
      tick_q    <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
`ifdef GF180MCU_CLKDIV_COMPL_OUT_EN
      clkon_q   <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      act_div_q <= act_div_d;
      nxt_div_q <= nxt_div_d;
      clko_q    <= clko_d;
      tick_q    <= tick_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
`ifdef GF180MCU_CLKDIV_COMPL_OUT_EN
      clkon_q   <= ~clko_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (EN) state_d = RUN;
      end
      RUN: begin
        if (stop)     state_d = IDLE;
        else if (REQ) state_d = PEND;
      end
      PEND: begin
        if (stop)      state_d = IDLE;
        else if (fall) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    cnt_d     = cnt_q;
    clko_d    = clko_q;
    act_div_d = act_div_q;
    nxt_div_d = nxt_div_q;
    ack_d     = 1'b0;
    busy_d    = busy_q;

    if (state_q == IDLE) begin
      cnt_d  = '0;
      clko_d = 1'b0;
      if (REQ) begin
        act_div_d = DIV;
        ack_d     = 1'b1;
      end
    end else begin
      if (at_top) begin
        cnt_d  = '0;
        clko_d = ~clko_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end

      if (stop) begin
        cnt_d  = '0;
        clko_d = 1'b0;
      end

      if ((state_q == RUN) && !stop && REQ) begin
        nxt_div_d = DIV;
        busy_d    = 1'b1;
      end

      // Pending ratio lands on the falling boundary, never inside a high phase.
      if ((state_q == PEND) && (stop || fall)) begin
        act_div_d = nxt_div_q;
        cnt_d     = '0;
        ack_d     = 1'b1;
        busy_d    = 1'b0;
      end
    end

    tick_d = clko_d & ~clko_q;
  end

  assign ACK  = ack_q;
  assign BUSY = busy_q;
  assign CLKO = clko_q;
  assign TICK = tick_q;
`ifdef GF180MCU_CLKDIV_COMPL_OUT_EN
  assign CLKON = clkon_q;
`endif

endmodule

// File: tb/tb_clkdiv_seq.sv
// Scoreboard bench for clkdiv_seq: expected output events (cycle-stamped) are queued
// by the stimulus and consumed by an independent monitor.
module tb_clkdiv_seq;

  localparam int K_TICK = 0;
  localparam int K_FALL = 1;
  localparam int K_ACK  = 2;
  localparam int K_BSET = 3;
  localparam int K_BCLR = 4;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] div;
  logic       req;
  logic       ack, busy, clko, tick;
`ifdef GF180MCU_CLKDIV_COMPL_OUT_EN
  logic       clkon;
`endif
  wire        vdd;
  wire        vss;
  assign vdd = 1'b1;
  assign vss = 1'b0;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b0;
  logic prev_clko = 1'b0;
  logic prev_busy = 1'b0;
  ev_t  exp_q[$];

  clkdiv_seq dut (
    .CLK  (clk),
    .RST  (rst),
    .EN   (en),
    .DIV  (div),
    .REQ  (req),
    .ACK  (ack),
    .BUSY (busy),
    .CLKO (clko),
    .TICK (tick),
`ifdef GF180MCU_CLKDIV_COMPL_OUT_EN
    .CLKON(clkon),
`endif
    .VDD  (vdd),
    .VSS  (vss)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_TICK:  return "TICK";
      K_FALL:  return "CLKO_FALL";
      K_ACK:   return "ACK";
      K_BSET:  return "BUSY_SET";
      K_BCLR:  return "BUSY_CLR";
      default: return "?";
    endcase
  endfunction

  task automatic push(input int k, input int c);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic got(input int k);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL event: got %s at cycle %0d, expected no event", kname(k), cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc) begin
        miscompares++;
        $display("FAIL event: got %s at cycle %0d, expected %s at cycle %0d",
                 kname(k), cyc, kname(e.kind), e.cyc);
      end
    end
  endtask

  task automatic check(input string name, input logic act, input logic req_v);
    vectors++;
    if (act !== req_v) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, req_v, cyc);
    end
  endtask

  task automatic at_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: turns output changes into events and checks them against the queue
  always @(negedge clk) begin
    if (mon_en) begin
      if ((clko && !prev_clko) || tick) check("tick_vs_rise", tick, clko && !prev_clko);
      if (tick)                got(K_TICK);
      if (prev_clko && !clko)  got(K_FALL);
      if (ack)                 got(K_ACK);
      if (busy && !prev_busy)  got(K_BSET);
      if (!busy && prev_busy)  got(K_BCLR);
`ifdef GF180MCU_CLKDIV_COMPL_OUT_EN
      check("clkon_compl", clkon, ~clko);
`endif
    end
    prev_clko <= clko;
    prev_busy <= busy;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b, c, d, e;
    rst = 1'b1; en = 1'b0; req = 1'b0; div = 4'd0;

    // Reset state
    at_cyc(3);
    check("rst_clko", clko, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ack",  ack,  1'b0);
    check("rst_tick", tick, 1'b0);
    mon_en = 1'b1;

    // Default ratio: period 4, first rise 2 cycles after RUN entry
    push(K_TICK, 6); push(K_FALL, 8); push(K_TICK, 10); push(K_FALL, 12);
    rst = 1'b0; en = 1'b1;
    at_cyc(12); en = 1'b0;

    // Ratio change in IDLE, then period 8
    b = 20;
    push(K_ACK, b+1); push(K_TICK, b+7); push(K_FALL, b+11);
    push(K_TICK, b+15); push(K_FALL, b+19);
    at_cyc(b);    req = 1'b1; div = 4'd3;
    at_cyc(b+1);  req = 1'b0;
    at_cyc(b+2);  en = 1'b1;
    at_cyc(b+19); en = 1'b0;

    // Mid-high change 1->0, boundary REQ ignored, BUSY REQ ignored, disable while high
    c = 45;
    push(K_ACK, c+1);  push(K_TICK, c+3);  push(K_FALL, c+5);  push(K_TICK, c+7);
    push(K_BSET, c+8); push(K_FALL, c+9);  push(K_ACK, c+9);   push(K_BCLR, c+9);
    push(K_TICK, c+10); push(K_FALL, c+11); push(K_TICK, c+12); push(K_FALL, c+13);
    push(K_TICK, c+14); push(K_BSET, c+14); push(K_FALL, c+15); push(K_ACK, c+15);
    push(K_BCLR, c+15); push(K_TICK, c+18); push(K_BSET, c+19); push(K_FALL, c+21);
    push(K_ACK, c+21);  push(K_BCLR, c+21); push(K_TICK, c+23); push(K_FALL, c+25);
    push(K_TICK, c+27); push(K_FALL, c+29); push(K_BSET, c+30); push(K_TICK, c+31);
    push(K_FALL, c+33); push(K_ACK, c+33);  push(K_BCLR, c+33); push(K_TICK, c+36);
    push(K_FALL, c+39);
    at_cyc(c);    req = 1'b1; div = 4'd1; en = 1'b1;
    at_cyc(c+1);  req = 1'b0;
    at_cyc(c+7);  req = 1'b1; div = 4'd0;
    at_cyc(c+8);  req = 1'b0;
    at_cyc(c+13); req = 1'b1; div = 4'd2;
    at_cyc(c+14); div = 4'd7;
    at_cyc(c+15); req = 1'b0;
    at_cyc(c+18); req = 1'b1; div = 4'd1;
    at_cyc(c+19); div = 4'd7;
    at_cyc(c+20); req = 1'b0;
    at_cyc(c+29); req = 1'b1; div = 4'd2;
    at_cyc(c+30); req = 1'b0;
    at_cyc(c+37); en = 1'b0;

    // DIV=15 (CLK/32); pending ratio applied on entry to IDLE
    d = 100;
    push(K_ACK, d+1);   push(K_TICK, d+17); push(K_FALL, d+33); push(K_TICK, d+49);
    push(K_BSET, d+50); push(K_FALL, d+65); push(K_ACK, d+65);  push(K_BCLR, d+65);
    at_cyc(d);    req = 1'b1; div = 4'd15; en = 1'b1;
    at_cyc(d+1);  req = 1'b0;
    at_cyc(d+49); en = 1'b0; req = 1'b1; div = 4'd0;
    at_cyc(d+50); req = 1'b0;

    // Ratio 0 now active; reset mid-high with a pending change discards it
    e = d + 70;
    push(K_TICK, e+2); push(K_FALL, e+3); push(K_TICK, e+4); push(K_BSET, e+4);
    push(K_FALL, e+5); push(K_BCLR, e+5); push(K_TICK, e+8); push(K_FALL, e+10);
    at_cyc(e);    en = 1'b1;
    at_cyc(e+3);  req = 1'b1; div = 4'd3;
    at_cyc(e+4);  req = 1'b0; rst = 1'b1;
    at_cyc(e+5);
    check("mid_rst_clko", clko, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ack",  ack,  1'b0);
    check("mid_rst_tick", tick, 1'b0);
`ifdef GF180MCU_CLKDIV_COMPL_OUT_EN
    check("mid_rst_clkon", clkon, 1'b1);
`endif
    rst = 1'b0;
    at_cyc(e+10); en = 1'b0;

    at_cyc(e+30);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover: %0d expected events not seen, next %s at cycle %0d",
               exp_q.size(), kname(exp_q[0].kind), exp_q[0].cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
